// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared op encodings, FSM states and width for the HI/LO multiply/divide unit
package mdu_pkg;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [1:0] {
        MDU_MULT  = 2'b00,
        MDU_MULTU = 2'b01,
        MDU_DIV   = 2'b10,
        MDU_DIVU  = 2'b11
    } mdu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIN  = 2'b10
    } mdu_state_e;

endpackage

// File: rtl/mult_div_unit_if.sv
// rtl/mult_div_unit_if.sv - launch/result bundle between the datapath and the multiply/divide unit
interface mult_div_unit_if #(parameter int WIDTH = mdu_pkg::MDU_WIDTH);

    logic             Start;
    logic [1:0]       Op;
    logic [WIDTH-1:0] SrcA;
    logic [WIDTH-1:0] SrcB;
    logic             HiWrite;
    logic             LoWrite;
    logic             Busy;
    logic             Done;
    logic             DivByZero;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output Start, Op, SrcA, SrcB, HiWrite, LoWrite,
        input  Busy, Done, DivByZero, Hi, Lo
    );

    modport slave (
        input  Start, Op, SrcA, SrcB, HiWrite, LoWrite,
        output Busy, Done, DivByZero, Hi, Lo
    );

endinterface

// File: rtl/mdu_step.sv
// rtl/mdu_step.sv - one iteration of unsigned shift-add multiply or restoring divide
module mdu_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] q_next
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] trial;

    always_comb begin
        sum   = {1'b0, acc} + {1'b0, d};
        trial = {acc, q[WIDTH-1]} - {1'b0, d};
        acc_next = acc;
        q_next   = q;
        if (is_div) begin
            // Remainder stays below the divisor, so bit WIDTH of the trial is a clean borrow flag.
            if (!trial[WIDTH]) begin
                acc_next = trial[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {acc[WIDTH-2:0], q[WIDTH-1]};
                q_next   = {q[WIDTH-2:0], 1'b0};
            end
        end else if (q[0]) begin
            {acc_next, q_next} = {sum, q[WIDTH-1:1]};
        end else begin
            {acc_next, q_next} = {1'b0, acc, q[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit holding the architectural HI/LO registers
module mult_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    mult_div_unit_if.slave   bus
);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_q, q_q, d_q, a_raw_q, hi_q, lo_q;
    logic               is_div_q, neg_q, sa_q, dz_q;

    logic               start_ok, is_div, is_signed, sa, sb, last;
    logic [WIDTH-1:0]   a_mag, b_mag, acc_n, q_n, fix_hi, fix_lo;
    logic [2*WIDTH-1:0] prod;

    assign is_div    = (bus.Op == MDU_DIV) || (bus.Op == MDU_DIVU);
    assign is_signed = (bus.Op == MDU_MULT) || (bus.Op == MDU_DIV);
    assign sa        = is_signed & bus.SrcA[WIDTH-1];
    assign sb        = is_signed & bus.SrcB[WIDTH-1];
    assign a_mag     = sa ? -bus.SrcA : bus.SrcA;
    assign b_mag     = sb ? -bus.SrcB : bus.SrcB;
    assign start_ok  = bus.Start && (state_q != S_RUN);
    assign last      = (cnt_q == CNT_W'(WIDTH-1));

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div_q),
        .acc      (acc_q),
        .q        (q_q),
        .d        (d_q),
        .acc_next (acc_n),
        .q_next   (q_n)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (bus.Start) state_d = S_RUN;
            S_RUN:   if (last) state_d = S_FIN;
            S_FIN:   state_d = bus.Start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Sign fix-up of the final step; INT_MIN / -1 falls out naturally as 0x8000_0000 rem 0.
    always_comb begin
        prod = {acc_n, q_n};
        if (neg_q) prod = -prod;
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (is_div_q) begin
            if (dz_q) begin
                fix_lo = '1;
                fix_hi = a_raw_q;
            end else begin
                fix_lo = neg_q ? -q_n : q_n;
                fix_hi = sa_q ? -acc_n : acc_n;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= '0;
            d_q      <= '0;
            a_raw_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sa_q     <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start_ok) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            q_q      <= is_div ? a_mag : b_mag;
            d_q      <= is_div ? b_mag : a_mag;
            a_raw_q  <= bus.SrcA;
            is_div_q <= is_div;
            neg_q    <= sa ^ sb;
            sa_q     <= sa;
            dz_q     <= is_div && (bus.SrcB == '0);
        end else if (state_q == S_RUN) begin
            acc_q <= acc_n;
            q_q   <= q_n;
            if (last) begin
                hi_q <= fix_hi;
                lo_q <= fix_lo;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end else begin
            if (bus.HiWrite) hi_q <= bus.SrcA;
            if (bus.LoWrite) lo_q <= bus.SrcA;
        end
    end

    assign bus.Busy      = (state_q == S_RUN);
    assign bus.Done      = (state_q == S_FIN);
    assign bus.DivByZero = (state_q == S_FIN) && dz_q;
    assign bus.Hi        = hi_q;
    assign bus.Lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed vectors against a timestamp/arithmetic model of the multiply/divide unit
module tb_mult_div_unit;
    import mdu_pkg::*;

    localparam int W = MDU_WIDTH;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    mult_div_unit_if #(.WIDTH(W)) bus();

    mult_div_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {div_by_zero, hi, lo} straight from the arithmetic definition of each op.
    function automatic logic [64:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            MDU_MULT:  begin p = longint'(sa) * longint'(sb); return {1'b0, p[63:0]}; end
            MDU_MULTU: begin p = longint'({32'd0, a}) * longint'({32'd0, b}); return {1'b0, p[63:0]}; end
            MDU_DIV: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {1'b0, 32'd0, 32'h8000_0000};
                return {1'b0, 32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
                return {1'b0, a % b, a / b};
            end
        endcase
    endfunction

    // Model: an accepted op started at edge st is busy after edges st..st+W-1 and completes at edge st+W.
    int          edge_cnt = 0;
    int          st = 0;
    bit          active = 1'b0;
    bit          prev_busy;
    logic [31:0] m_hi = '0, m_lo = '0, r_hi = '0, r_lo = '0;
    bit          r_dz = 1'b0;
    bit          e_busy = 1'b0, e_done = 1'b0, e_dz = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active = 1'b0;
            m_hi = '0;
            m_lo = '0;
            e_busy = 1'b0;
            e_done = 1'b0;
            e_dz = 1'b0;
        end else begin
            edge_cnt++;
            prev_busy = active && (edge_cnt - 1 >= st) && (edge_cnt - 1 < st + W);
            e_done = active && (edge_cnt == st + W);
            e_dz = e_done && r_dz;
            if (e_done) begin
                m_hi = r_hi;
                m_lo = r_lo;
            end
            if (!prev_busy) begin
                if (bus.Start) begin
                    st = edge_cnt;
                    active = 1'b1;
                    {r_dz, r_hi, r_lo} = model(bus.Op, bus.SrcA, bus.SrcB);
                end else begin
                    if (bus.HiWrite) m_hi = bus.SrcA;
                    if (bus.LoWrite) m_lo = bus.SrcA;
                end
            end
            e_busy = active && (edge_cnt >= st) && (edge_cnt < st + W);
        end
    end

    always @(negedge clk) begin
        check("busy", 64'(bus.Busy), 64'(e_busy));
        check("done", 64'(bus.Done), 64'(e_done));
        check("div_by_zero", 64'(bus.DivByZero), 64'(e_dz));
        check("hi", 64'(bus.Hi), 64'(m_hi));
        check("lo", 64'(bus.Lo), 64'(m_lo));
    end

    task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, output int s);
        @(negedge clk);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.SrcA  = a;
        bus.SrcB  = b;
        @(negedge clk);
        bus.Start = 1'b0;
        s = edge_cnt;
    endtask

    task automatic wait_done(output int de, output int busy_cycles);
        bit seen;
        seen = 1'b0;
        de = 0;
        busy_cycles = bus.Busy ? 1 : 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (bus.Busy) busy_cycles++;
            if (bus.Done) begin
                seen = 1'b1;
                de = edge_cnt;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_timeout: got no Done expected Done within 100 cycles");
        end
    endtask

    task automatic run(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] hi, input logic [31:0] lo, input logic dz);
        int s, de, bc;
        start_op(op, a, b, s);
        wait_done(de, bc);
        check({name, "_hi"}, 64'(bus.Hi), 64'(hi));
        check({name, "_lo"}, 64'(bus.Lo), 64'(lo));
        check({name, "_dz"}, 64'(bus.DivByZero), 64'(dz));
    endtask

    initial begin
        int s, s2, de, de2, bc;
        bus.Start = 1'b0; bus.Op = 2'b00; bus.SrcA = '0; bus.SrcB = '0;
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_hi", 64'(bus.Hi), 64'd0);
        check("reset_lo", 64'(bus.Lo), 64'd0);
        rst_n = 1'b1;

        start_op(MDU_MULTU, 32'hFFFF_FFFF, 32'h2, s);
        wait_done(de, bc);
        check("multu_latency", 64'(de - s), 64'(W));
        check("multu_busy_cycles", 64'(bc), 64'(W));
        check("multu_hi", 64'(bus.Hi), 64'h1);
        check("multu_lo", 64'(bus.Lo), 64'hFFFF_FFFE);

        run("mult",   MDU_MULT, -32'sd3, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        run("div",    MDU_DIV,  -32'sd7, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run("divu",   MDU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run("divu_z", MDU_DIVU, 32'h1234, 32'd0, 32'h1234, 32'hFFFF_FFFF, 1'b1);
        run("div_z",  MDU_DIV,  -32'sd9, 32'd0, 32'hFFFF_FFF7, 32'hFFFF_FFFF, 1'b1);
        run("intmin", MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        run("div_nd", MDU_DIV,  32'd100, -32'sd7, 32'd2, 32'hFFFF_FFF2, 1'b0);

        // Start and HiWrite pulses mid-operation must be ignored.
        start_op(MDU_DIVU, 32'd1000, 32'd10, s);
        repeat (3) @(negedge clk);
        bus.Start = 1'b1; bus.Op = MDU_MULT; bus.SrcA = 32'd5; bus.SrcB = 32'd5; bus.HiWrite = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0; bus.HiWrite = 1'b0;
        wait_done(de, bc);
        check("ignore_lo", 64'(bus.Lo), 64'd100);
        check("ignore_hi", 64'(bus.Hi), 64'd0);
        bus.Start = 1'b1; bus.Op = MDU_DIVU; bus.SrcA = 32'd100; bus.SrcB = 32'd7;
        @(negedge clk);
        bus.Start = 1'b0;
        s2 = edge_cnt;
        wait_done(de2, bc);
        check("b2b_start_edge", 64'(s2 - de), 64'd1);
        check("b2b_done_gap", 64'(de2 - de), 64'(W + 1));
        check("b2b_lo", 64'(bus.Lo), 64'd14);

        bus.HiWrite = 1'b1; bus.SrcA = 32'hCAFE_0001;
        @(negedge clk);
        bus.HiWrite = 1'b0;
        check("mthi", 64'(bus.Hi), 64'hCAFE_0001);
        check("mthi_lo_kept", 64'(bus.Lo), 64'd14);
        bus.HiWrite = 1'b1; bus.LoWrite = 1'b1; bus.SrcA = 32'h5555_AAAA;
        @(negedge clk);
        bus.HiWrite = 1'b0; bus.LoWrite = 1'b0;
        check("mthi_mtlo_hi", 64'(bus.Hi), 64'h5555_AAAA);
        check("mthi_mtlo_lo", 64'(bus.Lo), 64'h5555_AAAA);
        bus.Start = 1'b1; bus.HiWrite = 1'b1; bus.Op = MDU_MULTU; bus.SrcA = 32'd3; bus.SrcB = 32'd4;
        @(negedge clk);
        bus.Start = 1'b0; bus.HiWrite = 1'b0;
        check("start_wins_hi", 64'(bus.Hi), 64'h5555_AAAA);
        wait_done(de, bc);
        check("start_wins_lo", 64'(bus.Lo), 64'd12);

        // Reset ten cycles into a MULT aborts it and clears HI/LO at once.
        start_op(MDU_MULT, -32'sd5, 32'd9, s);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_hi", 64'(bus.Hi), 64'd0);
        check("abort_lo", 64'(bus.Lo), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        run("after_rst", MDU_MULT, -32'sd5, 32'd9, 32'hFFFF_FFFF, 32'hFFFF_FFD3, 1'b0);
        repeat (3) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
